// File: rtl/apb_req_arbiter_pkg.sv
// rtl/apb_req_arbiter_pkg.sv - shared types and defaults for the two-requester APB arbiter
//
// Contents:
//   state_e      : arbiter FSM states (IDLE, BUSY, RELEASE)
//   DEF_ADDR_W   : default requester/master address width
//   DEF_DATA_W   : default requester/master data width
//   DEF_TIMEOUT  : default pready wait limit in BUSY cycles (1..255)
//   CNT_W        : wait counter width, wide enough for the largest legal limit
//   onehot2()    : requester index to one-hot grant vector
package apb_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int CNT_W       = 8;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// rtl/apb_req_arbiter_rr_arb2.sv - combinational 2-way round-robin grant decision
//
// Ports:
//   req_i  [1:0] : request vector, bit i = requester i
//   last_i       : index of the requester granted last time
//   gnt_o  [1:0] : one-hot winner, 0 when nothing is requested
//   win_o        : index of the winner (0 when nothing is requested)
module rr_arb2
  import apb_req_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  always_comb begin
    win_o = 1'b0;
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      // Contention: the side that did not win last time goes next.
      win_o = ~last_i;
    end else begin
      // A lone requester wins whatever the pointer says.
      win_o = req_i[1];
    end
    if (req_i != 2'b00) begin
      gnt_o = onehot2(win_o);
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - shares one APB master between two requesters with timeout abort
//
// Ports:
//   clk, rstn            : clock, asynchronous active-low reset
//   req, req_wr          : per-requester request and direction (1 = write)
//   req_addr, req_wdata  : packed per-requester address / write data, requester i at [i*W +: W]
//   gnt                  : one-hot owner of the transfer in flight, 0 when idle
//   done, err            : one-cycle completion pulse to the owner, err flags a timeout
//   rdata                : read data captured from the last successful read
//   newd, wr, ain, din   : transfer request, direction, address and write data to the APB master
//   pready, dout         : completion from the slave and read data from the APB master
module apb_req_arbiter
  import apb_req_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                newd,
  output logic                wr,
  output logic [ADDR_W-1:0]   ain,
  output logic [DATA_W-1:0]   din,
  input  logic                pready,
  input  logic [DATA_W-1:0]   dout
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  state_e             state_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [1:0]         gnt_q;
  logic [1:0]         done_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               newd_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  ain_q;
  logic [DATA_W-1:0]  din_q;

  logic [1:0]         arb_gnt;
  logic               arb_win;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .win_o  (arb_win)
  );

  // Winner's transfer fields, only consumed on the IDLE->BUSY edge.
  assign sel_wr    = arb_win ? req_wr[1] : req_wr[0];
  assign sel_addr  = arb_win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wdata = arb_win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Count of BUSY cycles that will have elapsed without pready after this edge.
  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= '0;
      newd_q  <= 1'b0;
      wr_q    <= 1'b0;
      ain_q   <= '0;
      din_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= BUSY;
            gnt_q   <= arb_gnt;
            last_q  <= arb_win;
            wr_q    <= sel_wr;
            ain_q   <= sel_addr;
            din_q   <= sel_wdata;
            newd_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          // pready takes priority so a response on the final allowed cycle is a success.
          if (pready) begin
            if (!wr_q) begin
              rdata_q <= dout;
            end
            done_q  <= gnt_q;
            err_q   <= 1'b0;
            newd_q  <= 1'b0;
            state_q <= RELEASE;
          end else if (cnt_d == TO_LIMIT) begin
            done_q  <= gnt_q;
            err_q   <= 1'b1;
            newd_q  <= 1'b0;
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RELEASE: begin
          done_q  <= 2'b00;
          err_q   <= 1'b0;
          gnt_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign newd  = newd_q;
  assign wr    = wr_q;
  assign ain   = ain_q;
  assign din   = din_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - directed self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] req;
  logic [1:0] req_wr;
  logic [7:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic [7:0] rdata;
  logic       newd;
  logic       wr;
  logic [3:0] ain;
  logic [7:0] din;
  logic       pready;
  logic [7:0] dout;

  int checks;
  int failures;

  apb_req_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .newd      (newd),
    .wr        (wr),
    .ain       (ain),
    .din       (din),
    .pready    (pready),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0; req = 2'b00; req_wr = 2'b00; req_addr = 8'h00; req_wdata = 16'h0000;
    pready = 1'b0; dout = 8'h00;
    tick; tick;
    checks++;
    if ({gnt, done, err, newd, wr, ain, din, rdata} !== 27'd0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b done=%b err=%b newd=%b wr=%b ain=%h din=%h rdata=%h exp all 0",
               gnt, done, err, newd, wr, ain, din, rdata);
    end
    rstn = 1'b1;
    tick;
    checks++;
    if (newd !== 1'b0 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle got newd=%b gnt=%b exp 0 00", newd, gnt);
    end
  endtask

  // First contention after reset must go to requester 0.
  task automatic test_first_contention;
    req = 2'b11; req_wr = 2'b11; req_addr = 8'h21; req_wdata = 16'h2211;
    tick;
    checks++;
    if (gnt !== 2'b01 || ain !== 4'h1 || din !== 8'h11) begin
      failures++;
      $display("FAIL first_contention got gnt=%b ain=%h din=%h exp 01 1 11", gnt, ain, din);
    end
    pready = 1'b1;
    tick;
    pready = 1'b0; req = 2'b00;
    tick;
  endtask

  task automatic test_single_write;
    // Pointer now says requester 0 was last; a lone request from 0 still wins.
    pready = 1'b1;  // ignored while idle
    tick;
    checks++;
    if (done !== 2'b00 || newd !== 1'b0) begin
      failures++;
      $display("FAIL idle_pready_ignored got done=%b newd=%b exp 00 0", done, newd);
    end
    pready = 1'b0;
    req = 2'b01; req_wr = 2'b01; req_addr = 8'h03; req_wdata = 16'h00A5;
    tick;
    checks++;
    if (newd !== 1'b1 || gnt !== 2'b01 || ain !== 4'h3 || din !== 8'hA5 || wr !== 1'b1) begin
      failures++;
      $display("FAIL wr_start got newd=%b gnt=%b ain=%h din=%h wr=%b exp 1 01 3 a5 1", newd, gnt, ain, din, wr);
    end
    // Inputs changing mid-transfer must not disturb it.
    req_wr = 2'b00; req_addr = 8'hFE; req_wdata = 16'h1234;
    tick; tick;
    checks++;
    if (newd !== 1'b1 || ain !== 4'h3 || din !== 8'hA5 || wr !== 1'b1 || done !== 2'b00) begin
      failures++;
      $display("FAIL wr_hold got newd=%b ain=%h din=%h wr=%b done=%b exp 1 3 a5 1 00", newd, ain, din, wr, done);
    end
    pready = 1'b1;
    tick;
    checks++;
    if (done !== 2'b01 || err !== 1'b0 || newd !== 1'b0 || gnt !== 2'b01) begin
      failures++;
      $display("FAIL wr_done got done=%b err=%b newd=%b gnt=%b exp 01 0 0 01", done, err, newd, gnt);
    end
    pready = 1'b1; req = 2'b00;  // pready in RELEASE ignored
    tick;
    pready = 1'b0;
    checks++;
    if (done !== 2'b00 || gnt !== 2'b00 || newd !== 1'b0) begin
      failures++;
      $display("FAIL wr_release got done=%b gnt=%b newd=%b exp 00 00 0", done, gnt, newd);
    end
  endtask

  task automatic test_single_read;
    req = 2'b10; req_wr = 2'b00; req_addr = 8'h70; req_wdata = 16'h0000;
    tick;
    checks++;
    if (gnt !== 2'b10 || ain !== 4'h7 || wr !== 1'b0 || newd !== 1'b1) begin
      failures++;
      $display("FAIL rd_start got gnt=%b ain=%h wr=%b newd=%b exp 10 7 0 1", gnt, ain, wr, newd);
    end
    req = 2'b00;  // dropping req does not cancel
    dout = 8'h5C; pready = 1'b1;
    tick;
    pready = 1'b0; dout = 8'h00;
    checks++;
    if (done !== 2'b10 || rdata !== 8'h5C || gnt !== 2'b10 || err !== 1'b0) begin
      failures++;
      $display("FAIL rd_done got done=%b rdata=%h gnt=%b err=%b exp 10 5c 10 0", done, rdata, gnt, err);
    end
    tick;
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt [4];
    int low;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    req = 2'b11; req_wr = 2'b11; req_addr = 8'h98; req_wdata = 16'hBBAA;
    for (int k = 0; k < 4; k++) begin
      low = 0;
      while (newd !== 1'b1 && low < 10) begin
        low++;
        tick;
      end
      checks++;
      if (newd !== 1'b1) begin
        failures++;
        $display("FAIL cont_timeout xfer=%0d got newd=%b exp 1", k, newd);
      end
      if (k > 0) begin
        checks++;
        if (low < 2) begin
          failures++;
          $display("FAIL cont_gap xfer=%0d got low=%0d exp >=2", k, low);
        end
      end
      checks++;
      if (gnt !== exp_gnt[k]) begin
        failures++;
        $display("FAIL cont_order xfer=%0d got gnt=%b exp %b", k, gnt, exp_gnt[k]);
      end
      pready = 1'b1;
      tick;
      pready = 1'b0;
      checks++;
      if (done !== exp_gnt[k]) begin
        failures++;
        $display("FAIL cont_done xfer=%0d got done=%b exp %b", k, done, exp_gnt[k]);
      end
    end
    req = 2'b00;
    tick;
  endtask

  task automatic test_timeout;
    int busy;
    req = 2'b01; req_wr = 2'b00; req_addr = 8'h05; dout = 8'hEE; pready = 1'b0;
    tick;
    busy = 0;
    while (newd === 1'b1 && busy < 40) begin
      busy++;
      tick;
    end
    checks++;
    if (busy != 15) begin
      failures++;
      $display("FAIL to_cycles got busy=%0d exp 15", busy);
    end
    checks++;
    if (done !== 2'b01 || err !== 1'b1 || rdata !== 8'h5C) begin
      failures++;
      $display("FAIL to_done got done=%b err=%b rdata=%h exp 01 1 5c", done, err, rdata);
    end
    req = 2'b00;
    tick;
    checks++;
    if (err !== 1'b0 || done !== 2'b00) begin
      failures++;
      $display("FAIL to_clear got err=%b done=%b exp 0 00", err, done);
    end
    // Next request serviced normally.
    req = 2'b10; req_wr = 2'b00; req_addr = 8'h40; dout = 8'h77; pready = 1'b1;
    tick;
    tick;
    pready = 1'b0; req = 2'b00;
    checks++;
    if (done !== 2'b10 || err !== 1'b0 || rdata !== 8'h77) begin
      failures++;
      $display("FAIL to_next got done=%b err=%b rdata=%h exp 10 0 77", done, err, rdata);
    end
    tick;
  endtask

  // pready arriving on the 15th BUSY cycle is a success, not a timeout.
  task automatic test_pready_at_limit;
    req = 2'b01; req_wr = 2'b00; req_addr = 8'h0A; dout = 8'h3C; pready = 1'b0;
    tick;
    for (int i = 0; i < 14; i++) tick;
    checks++;
    if (newd !== 1'b1 || done !== 2'b00) begin
      failures++;
      $display("FAIL lim_busy got newd=%b done=%b exp 1 00", newd, done);
    end
    pready = 1'b1;
    tick;
    pready = 1'b0; req = 2'b00;
    checks++;
    if (done !== 2'b01 || err !== 1'b0 || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL lim_done got done=%b err=%b rdata=%h exp 01 0 3c", done, err, rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid_busy;
    int seen_done;
    req = 2'b01; req_wr = 2'b01; req_addr = 8'h06; req_wdata = 16'h0099; pready = 1'b0;
    tick; tick; tick;  // now in the 3rd BUSY cycle
    checks++;
    if (newd !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got newd=%b exp 1", newd);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({gnt, done, err, newd, wr, ain, din, rdata} !== 27'd0) begin
      failures++;
      $display("FAIL rst_async got gnt=%b done=%b err=%b newd=%b wr=%b ain=%h din=%h rdata=%h exp all 0",
               gnt, done, err, newd, wr, ain, din, rdata);
    end
    req = 2'b10; req_wr = 2'b00; req_addr = 8'hB0;
    seen_done = 0;
    tick;
    if (done !== 2'b00) seen_done++;
    rstn = 1'b1;
    tick;
    if (done !== 2'b00) seen_done++;
    checks++;
    if (gnt !== 2'b10 || newd !== 1'b1 || ain !== 4'hB || seen_done != 0) begin
      failures++;
      $display("FAIL rst_resume got gnt=%b newd=%b ain=%h done_seen=%0d exp 10 1 b 0", gnt, newd, ain, seen_done);
    end
    pready = 1'b1; dout = 8'h12;
    tick;
    pready = 1'b0; req = 2'b00;
    checks++;
    if (done !== 2'b10 || rdata !== 8'h12) begin
      failures++;
      $display("FAIL rst_after_done got done=%b rdata=%h exp 10 12", done, rdata);
    end
    tick;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_first_contention;
    test_single_write;
    test_single_read;
    test_contention;
    test_timeout;
    test_pready_at_limit;
    test_reset_mid_busy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
